// File: rtl/sseg_scan_driver_if.sv
// sseg_scan_driver_if: display data load bus and scanned segment/anode outputs
//   load       capture hex_in/dp_in/blank_in into the shadow registers
//   hex_in     4 bits per digit, digit 0 in [3:0]
//   dp_in      per-digit decimal point, 0 = lit
//   blank_in   per-digit force-off, 1 = blank
//   lz_blank   leading-zero suppression enable (live)
//   sseg       active-low segments {dp, a..g}
//   an         active-low digit enables
//   frame_tick one-cycle pulse after each frame boundary
interface sseg_scan_driver_if #(parameter int N_DIGITS = 3);
  logic                  load;
  logic [4*N_DIGITS-1:0] hex_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blank_in;
  logic                  lz_blank;
  logic [7:0]            sseg;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_tick;
  modport master(output load, hex_in, dp_in, blank_in, lz_blank, input sseg, an, frame_tick);
  modport slave(input load, hex_in, dp_in, blank_in, lz_blank, output sseg, an, frame_tick);
endinterface

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: multiplexed 7-segment scanner with frame-synchronous double buffering
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    sseg_scan_driver_if.slave (load/data inputs, sseg/an/frame_tick outputs)
module sseg_scan_driver #(
  parameter int N_DIGITS = 3,
  parameter int DWELL    = 4000,
  parameter int GUARD    = 16
) (
  input logic clk,
  input logic reset,
  sseg_scan_driver_if.slave bus
);
  localparam int CW = $clog2(DWELL);
  localparam int IW = $clog2(N_DIGITS);
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic                  r_pend, r_ft;
  logic [4*N_DIGITS-1:0] r_sh_hex, r_act_hex;
  logic [N_DIGITS-1:0]   r_sh_dp, r_act_dp, r_sh_blank, r_act_blank, r_an;
  logic [7:0]            r_sseg;
  logic                  w_wrap, w_frame, w_dark, w_off;
  logic [N_DIGITS:0]     w_upz;
  logic [3:0]            w_nib;
  logic [N_DIGITS-1:0]   w_an;
  logic [7:0]            w_sseg;
  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction
  assign w_wrap  = r_cnt == CW'(DWELL - 1);
  assign w_frame = w_wrap && r_idx == IW'(N_DIGITS - 1);
  assign w_nib   = r_act_hex[4*r_idx +: 4];
  // w_upz[i]: active nibbles i..N_DIGITS-1 are all zero
  always_comb begin
    w_upz = '0;
    w_upz[N_DIGITS] = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) w_upz[i] = w_upz[i+1] & (r_act_hex[4*i +: 4] == 4'd0);
  end
  always_comb begin
    w_dark = r_act_blank[r_idx] | (bus.lz_blank & (r_idx != '0) & w_upz[r_idx]);
    w_off  = (r_cnt < CW'(GUARD)) | w_dark;
    w_an   = w_off ? '1 : ~(N_DIGITS'(1) << r_idx);
    w_sseg = w_off ? 8'hFF : {r_act_dp[r_idx], seg7(w_nib)};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_ft        <= 1'b0;
      r_pend      <= 1'b0;
      r_sh_hex    <= '0;
      r_act_hex   <= '0;
      r_sh_dp     <= '1;
      r_act_dp    <= '1;
      r_sh_blank  <= '0;
      r_act_blank <= '0;
      r_an        <= '1;
      r_sseg      <= 8'hFF;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) r_idx <= (r_idx == IW'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      r_ft <= w_frame;
      if (bus.load) begin
        r_sh_hex   <= bus.hex_in;
        r_sh_dp    <= bus.dp_in;
        r_sh_blank <= bus.blank_in;
      end
      // a load on the boundary cycle lands in shadow only; the older shadow is committed
      if (w_frame && r_pend) begin
        r_act_hex   <= r_sh_hex;
        r_act_dp    <= r_sh_dp;
        r_act_blank <= r_sh_blank;
      end
      r_pend <= bus.load | (r_pend & ~w_frame);
      r_an   <= w_an;
      r_sseg <= w_sseg;
    end
  assign bus.sseg       = r_sseg;
  assign bus.an         = r_an;
  assign bus.frame_tick = r_ft;
endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: directed and random scan checks against a cycle-count reference model
module tb_sseg_scan_driver;
  localparam int N = 3, DW = 8, GD = 1, FR = N * DW;
  logic clk, reset;
  int vectors = 0, errs = 0, k = 0;
  sseg_scan_driver_if #(.N_DIGITS(N)) bus ();
  sseg_scan_driver #(.N_DIGITS(N), .DWELL(DW), .GUARD(GD)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                           7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [11:0] m_sh_hex, m_act_hex;
  logic [2:0]  m_sh_dp, m_act_dp, m_sh_bl, m_act_bl;
  bit          m_staged;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, got, exp);
    end
  endtask
  task automatic model_reset();
    k = 0; m_staged = 0;
    m_sh_hex = 0; m_act_hex = 0; m_sh_dp = 3'b111; m_act_dp = 3'b111; m_sh_bl = 0; m_act_bl = 0;
  endtask
  // Edge number k since reset release: slot position k%DW, digit (k/DW)%N, frame ends at k%FR==FR-1.
  task automatic cyc();
    int c, d;
    bit off, bnd;
    logic [3:0] nib;
    logic [2:0] ea;
    logic [7:0] es;
    c = k % DW; d = (k / DW) % N;
    nib = 4'(m_act_hex >> (4 * d));
    off = (c < GD) || m_act_bl[d] || (bus.lz_blank && d > 0 && (m_act_hex >> (4 * d)) == 0);
    ea = off ? 3'b111 : 3'b111 ^ (3'b001 << d);
    es = off ? 8'hFF : {m_act_dp[d], pat[nib]};
    bnd = (k % FR) == FR - 1;
    @(posedge clk);
    if (bnd && m_staged) begin m_act_hex = m_sh_hex; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl; end
    m_staged = bus.load || (m_staged && !bnd);
    if (bus.load) begin m_sh_hex = bus.hex_in; m_sh_dp = bus.dp_in; m_sh_bl = bus.blank_in; end
    k++;
    #1;
    chk("an", 8'(bus.an), 8'(ea));
    chk("sseg", bus.sseg, es);
    chk("frame_tick", 8'(bus.frame_tick), 8'(bnd));
  endtask
  task automatic ld(input logic [11:0] h, input logic [2:0] dp, input logic [2:0] bl);
    bus.hex_in = h; bus.dp_in = dp; bus.blank_in = bl; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic chk_reset();
    chk("rst_an", 8'(bus.an), 8'h07);
    chk("rst_sseg", bus.sseg, 8'hFF);
    chk("rst_ft", 8'(bus.frame_tick), 8'h00);
  endtask
  initial begin
    reset = 1'b1; bus.load = 0; bus.hex_in = 0; bus.dp_in = 3'b111; bus.blank_in = 0; bus.lz_blank = 0;
    model_reset();
    #12;
    chk_reset();
    reset = 1'b0;
    run(2 * FR + 5);
    ld(12'h3A7, 3'b101, 3'b000);
    run(2 * FR);
    while (k % FR != FR - 1) cyc();
    ld(12'h9C4, 3'b011, 3'b000);
    run(2 * FR + 3);
    bus.lz_blank = 1;
    ld(12'h005, 3'b111, 3'b000);
    run(2 * FR);
    ld(12'h000, 3'b111, 3'b000);
    run(2 * FR);
    bus.lz_blank = 0;
    ld(12'h1E8, 3'b110, 3'b010);
    run(2 * FR);
    for (int i = 0; i < 400; i++) begin
      bus.lz_blank = 1'($urandom_range(0, 1));
      bus.hex_in = 12'($urandom);
      bus.dp_in = 3'($urandom);
      bus.blank_in = 3'($urandom);
      bus.hex_in = ($urandom_range(0, 3) == 0) ? 12'(bus.hex_in & 12'h00F) : bus.hex_in;
      bus.load = ($urandom_range(0, 7) == 0);
      cyc();
    end
    bus.load = 0; bus.lz_blank = 0;
    ld(12'h000, 3'b111, 3'b000);
    run(FR + 5);
    while (k % FR != DW + 2) cyc();
    ld(12'h999, 3'b000, 3'b000);
    reset = 1'b1;
    #1;
    chk_reset();
    @(posedge clk);
    #1;
    chk_reset();
    reset = 1'b0;
    model_reset();
    run(2 * FR);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
